// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Purpose  : Shared types and constants for the APB3 completer register file.
//            Holds the bus widths, the completer FSM state encoding and the
//            address-window hit helper used by the decoder.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } apb_state_e;

    // Word-aligned hit inside [base, base + 4*nregs). The upper bound is formed
    // in 33 bits so a window ending exactly at 2^32 does not wrap to zero.
    function automatic logic addr_hit(
        input logic [APB_ADDR_W-1:0] addr,
        input logic [APB_ADDR_W-1:0] base,
        input int unsigned           nregs
    );
        logic [APB_ADDR_W:0] end_addr;
        end_addr = {1'b0, base} + (33'(nregs) << 2);
        return (addr[1:0] == 2'b00) && (addr >= base) && ({1'b0, addr} < end_addr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_regbank.sv
`default_nettype none
// ============================================================================
// Module   : apb_regbank
// Purpose  : NUM_REGS x 32-bit register storage with one synchronous write
//            port and one combinational read port.
// Ports    : clk    in   clock
//            rst    in   synchronous active-high reset (all regs <- RESET_VAL)
//            we     in   write enable
//            waddr  in   write index
//            wdata  in   write data
//            raddr  in   read index
//            rdata  out  read data (combinational)
// Revision : 1.0  initial release
// ============================================================================
module apb_regbank
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS  = 16,
    parameter logic [APB_DATA_W-1:0] RESET_VAL = '0,
    parameter int                    IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/apb_completer_regfile.sv
`default_nettype none
// ============================================================================
// Module   : apb_completer_regfile
// Purpose  : APB3 completer terminating transfers into a word-aligned register
//            window. Decodes PADDR, inserts WAIT_CYCLES wait states, commits
//            writes to the register bank, returns read data and flags
//            out-of-window / misaligned accesses on PSLVERR. All bus outputs
//            are registered.
// Ports    : PCLK     in   clock, all state on rising edge
//            rst      in   synchronous active-high reset
//            PSEL     in   completer select
//            PENABLE  in   access-phase strobe
//            PADDR    in   byte address
//            PWRITE   in   1 = write, 0 = read
//            PWDATA   in   write data
//            PRDATA   out  read data, valid while PREADY = 1
//            PREADY   out  transfer completes when PSEL & PENABLE & PREADY
//            PSLVERR  out  error, valid while PREADY = 1
// Revision : 1.0  initial release
// ============================================================================
module apb_completer_regfile
    import apb_pkg::*;
#(
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0100,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [APB_DATA_W-1:0] RESET_VAL   = 32'h0
) (
    input  logic                  PCLK,
    input  logic                  rst,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [APB_ADDR_W-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [APB_DATA_W-1:0] PWDATA,
    output logic [APB_DATA_W-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] C_CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic       C_ZERO_WAIT = (WAIT_CYCLES == 0);

    apb_state_e            r_state;
    apb_state_e            w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;

    // Transfer attributes captured at the setup edge
    logic [IDX_W-1:0]      r_index;
    logic                  r_write;
    logic                  r_hit;
    logic [APB_DATA_W-1:0] r_wdata;

    logic                  w_hit;
    logic [IDX_W-1:0]      w_index;
    logic [IDX_W-1:0]      w_raddr;
    logic [APB_DATA_W-1:0] w_rdata;
    logic                  w_ent_hit;
    logic                  w_ent_write;

    logic                  w_latch;
    logic                  w_commit;
    logic                  w_pready_nxt;
    logic                  w_pslverr_nxt;
    logic [APB_DATA_W-1:0] w_prdata_nxt;

    assign w_hit   = addr_hit(PADDR, BASE_ADDR, NUM_REGS);
    assign w_index = IDX_W'((PADDR - BASE_ADDR) >> 2);

    // With zero wait states READY is entered on the setup edge itself, before
    // the latched copies exist, so the live bus decode feeds the READY entry.
    assign w_ent_hit   = (r_state == ST_IDLE) ? w_hit   : r_hit;
    assign w_ent_write = (r_state == ST_IDLE) ? PWRITE  : r_write;
    assign w_raddr     = (r_state == ST_IDLE) ? w_index : r_index;

    apb_regbank #(
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL),
        .IDX_W     (IDX_W)
    ) u_regbank (
        .clk   (PCLK),
        .rst   (rst),
        .we    (w_commit),
        .waddr (r_index),
        .wdata (r_wdata),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_latch       = 1'b0;
        w_commit      = 1'b0;
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
        w_prdata_nxt  = '0;

        case (r_state)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_latch = 1'b1;
                    if (C_ZERO_WAIT) begin
                        w_state_nxt   = ST_READY;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = !w_ent_hit;
                        w_prdata_nxt  = (!w_ent_write && w_ent_hit) ? w_rdata : '0;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = C_CNT_INIT;
                    end
                end
            end

            ST_WAIT: begin
                if (!PSEL) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt   = ST_READY;
                    w_pready_nxt  = 1'b1;
                    w_pslverr_nxt = !w_ent_hit;
                    w_prdata_nxt  = (!w_ent_write && w_ent_hit) ? w_rdata : '0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            ST_READY: begin
                if (PSEL && PENABLE) begin
                    w_commit    = r_write && r_hit;
                    w_state_nxt = ST_IDLE;
                end else if (!PSEL) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    // Selected but strobe not yet seen: keep the response up.
                    w_pready_nxt  = 1'b1;
                    w_pslverr_nxt = PSLVERR;
                    w_prdata_nxt  = PRDATA;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_index <= '0;
            r_write <= 1'b0;
            r_hit   <= 1'b0;
            r_wdata <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            PREADY  <= w_pready_nxt;
            PSLVERR <= w_pslverr_nxt;
            PRDATA  <= w_prdata_nxt;
            if (w_latch) begin
                r_index <= w_index;
                r_write <= PWRITE;
                r_hit   <= w_hit;
                r_wdata <= PWDATA;
            end
        end
    end

endmodule
`default_nettype wire
